// File: rtl/pbit_sweep_scheduler.sv
// Round-robin Gibbs-sweep scheduler for a p-circuit: one p-bit update per RNG sample, then a settle window.
// Optional beta annealing is built when PBIT_SWEEP_ANNEAL_EN is defined.
module pbit_sweep_scheduler #(
    parameter int N_PBITS         = 8,
    parameter int IDX_W           = 3,
    parameter int SETTLE_CYCLES   = 2,
    parameter int SWEEP_W         = 16,
    parameter int BETA_W          = 4,
    parameter int BETA_START      = 1,
    parameter int SWEEPS_PER_BETA = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [SWEEP_W-1:0] num_sweeps_i,
    input  logic               rng_valid_i,
    output logic               rng_ready_o,
    output logic               upd_en_o,
    output logic [IDX_W-1:0]   upd_idx_o,
    output logic [N_PBITS-1:0] upd_onehot_o,
    output logic [SWEEP_W-1:0] sweep_cnt_o,
    output logic [BETA_W-1:0]  beta_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RNG = 3'd1,
        S_ISSUE    = 3'd2,
        S_SETTLE   = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PBITS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic [SWEEP_W-1:0] limit_q, limit_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [SWEEP_W-1:0] sweep_inc_s;
    logic               adv_s;

`ifdef PBIT_SWEEP_ANNEAL_EN
    localparam int AN_W = (SWEEPS_PER_BETA > 1) ? $clog2(SWEEPS_PER_BETA) : 1;
    localparam logic [AN_W-1:0] AN_LAST = AN_W'(SWEEPS_PER_BETA - 1);
    logic [AN_W-1:0]   an_q, an_d;
    logic [BETA_W-1:0] beta_q, beta_d;
`endif

    assign sweep_inc_s = sweep_q + SWEEP_W'(1);

    // Next-state and datapath: abort overrides everything and freezes the counters.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sweep_d  = sweep_q;
        limit_d  = limit_q;
        settle_d = settle_q;
        adv_s    = 1'b0;
`ifdef PBIT_SWEEP_ANNEAL_EN
        an_d     = an_q;
        beta_d   = beta_q;
`endif
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        idx_d   = '0;
                        sweep_d = '0;
                        limit_d = num_sweeps_i;
`ifdef PBIT_SWEEP_ANNEAL_EN
                        an_d    = '0;
                        beta_d  = BETA_W'(BETA_START);
`endif
                        if (num_sweeps_i != '0) begin
                            state_d = S_WAIT_RNG;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT_RNG: begin
                    if (rng_valid_i) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_WAIT_RNG;
                    end
                end
                S_ISSUE: begin
                    settle_d = '0;
                    if (SETTLE_CYCLES == 0) begin
                        adv_s = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == SET_LAST) begin
                        adv_s = 1'b1;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Advance to the next p-bit; the last p-bit closes a sweep.
            if (adv_s) begin
                if (idx_q != IDX_LAST) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_WAIT_RNG;
                end else begin
                    idx_d   = '0;
                    sweep_d = sweep_inc_s;
`ifdef PBIT_SWEEP_ANNEAL_EN
                    if (an_q == AN_LAST) begin
                        an_d = '0;
                        if (beta_q != {BETA_W{1'b1}}) begin
                            beta_d = beta_q + BETA_W'(1);
                        end else begin
                            beta_d = beta_q;
                        end
                    end else begin
                        an_d = an_q + AN_W'(1);
                    end
`endif
                    if (sweep_inc_s == limit_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_RNG;
                    end
                end
            end else begin
                adv_s = 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            sweep_q  <= '0;
            limit_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sweep_q  <= sweep_d;
            limit_q  <= limit_d;
            settle_q <= settle_d;
        end
    end

`ifdef PBIT_SWEEP_ANNEAL_EN
    // Anneal counter and beta register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q   <= '0;
            beta_q <= BETA_W'(BETA_START);
        end else begin
            an_q   <= an_d;
            beta_q <= beta_d;
        end
    end
    assign beta_o = beta_q;
`else
    assign beta_o = {BETA_W{1'b1}};
`endif

    // Moore output decode.
    always_comb begin
        if (state_q == S_ISSUE) begin
            upd_onehot_o = N_PBITS'(1) << idx_q;
        end else begin
            upd_onehot_o = '0;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign rng_ready_o = (state_q == S_WAIT_RNG);
    assign upd_en_o    = (state_q == S_ISSUE);
    assign done_o      = (state_q == S_DONE);
    assign upd_idx_o   = idx_q;
    assign sweep_cnt_o = sweep_q;

endmodule
